// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame checker.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int STICKY_START = 0;
  localparam int STICKY_PAR   = 1;
  localparam int STICKY_STOP  = 2;

  // Requested stop count of 0 means 1; anything above the supported maximum saturates.
  function automatic int clamp_stop(input int req, input int max_stop);
    if (req == 0)       return 1;
    if (req > max_stop) return max_stop;
    return req;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; an increment coinciding with a clear restarts at 1.
module sat_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (inc)
      count <= clr ? CNT_WIDTH'(1) : ((&count) ? count : count + 1'b1);
    else if (clr)
      count <= '0;
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: start, LSB-first data, optional parity, 1..MAX_STOP_BITS stop bits.
// Error counters are built only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_STOP_BITS = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 par_en,
  input  logic                                 par_type,
  input  logic [$clog2(MAX_STOP_BITS+1)-1:0]   stop_num,
  input  logic                                 bit_valid,
  input  logic                                 bit_in,
  input  logic                                 frame_abort,
  input  logic                                 clr_err,
  output logic                                 busy,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic                                 frame_done,
  output logic                                 start_err,
  output logic                                 par_err,
  output logic                                 stop_err,
  output logic [2:0]                           sticky_err,
  output logic [CNT_WIDTH-1:0]                 err_cnt_par,
  output logic [CNT_WIDTH-1:0]                 err_cnt_stop
);

  localparam int SW  = $clog2(MAX_STOP_BITS+1);
  localparam int BCW = $clog2(DATA_WIDTH+1);

  state_e                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bcnt;
  logic                  par_acc, par_bad, stop_acc;
  logic                  cfg_par_en, cfg_par_type;
  logic [SW-1:0]         cfg_stop, stop_clamped;
  logic                  last_data, last_stop, step;
  logic [2:0]            sticky_set;

  assign stop_clamped = SW'(clamp_stop(int'(stop_num), MAX_STOP_BITS));
  assign last_data    = (bcnt == BCW'(DATA_WIDTH-1));
  assign last_stop    = (int'(bcnt) == int'(cfg_stop) - 1);
  assign step         = bit_valid & ~frame_abort;
  assign busy         = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_abort)
      state_nxt = IDLE;
    else if (bit_valid) begin
      case (state)
        IDLE:    if (!bit_in) state_nxt = DATA;
        DATA:    if (last_data) state_nxt = cfg_par_en ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    if (last_stop) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg        <= '0;
      bcnt         <= '0;
      par_acc      <= 1'b0;
      par_bad      <= 1'b0;
      stop_acc     <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_par_type <= PAR_EVEN;
      cfg_stop     <= SW'(1);
      data_out     <= '0;
      frame_done   <= 1'b0;
      start_err    <= 1'b0;
      par_err      <= 1'b0;
      stop_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      start_err  <= 1'b0;
      if (step) begin
        case (state)
          IDLE: begin
            if (bit_in)
              start_err <= 1'b1;
            else begin
              cfg_par_en   <= par_en;
              cfg_par_type <= par_type;
              cfg_stop     <= stop_clamped;
              par_acc      <= 1'b0;
              par_bad      <= 1'b0;
              stop_acc     <= 1'b0;
              bcnt         <= '0;
            end
          end
          DATA: begin
            shreg   <= {bit_in, shreg[DATA_WIDTH-1:1]};
            par_acc <= par_acc ^ bit_in;
            bcnt    <= last_data ? '0 : bcnt + BCW'(1);
          end
          PARITY: par_bad <= par_acc ^ bit_in ^ (cfg_par_type == PAR_ODD);
          STOP: begin
            // Every stop bit is sampled; an early 0 does not end the frame.
            if (last_stop) begin
              frame_done <= 1'b1;
              data_out   <= shreg;
              par_err    <= cfg_par_en & par_bad;
              stop_err   <= stop_acc | ~bit_in;
            end else begin
              stop_acc <= stop_acc | ~bit_in;
              bcnt     <= bcnt + BCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Set sources are the registered pulses, so a clear landing on a pulse cycle loses.
  always_comb begin
    sticky_set               = '0;
    sticky_set[STICKY_START] = start_err;
    sticky_set[STICKY_PAR]   = frame_done & par_err;
    sticky_set[STICKY_STOP]  = frame_done & stop_err;
  end

  always_ff @(posedge CLK) begin
    if (RST) sticky_err <= '0;
    else     sticky_err <= sticky_set | (sticky_err & {3{~clr_err}});
  end

`ifdef UART_RX_ERR_CNT_EN
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_par (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (frame_done & par_err),
    .clr   (clr_err),
    .count (err_cnt_par)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_stop (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (frame_done & stop_err),
    .clr   (clr_err),
    .count (err_cnt_stop)
  );
`else
  assign err_cnt_par  = '0;
  assign err_cnt_stop = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (8 data bits, up to 2 stop bits, 2-bit counters).
module tb_uart_rx_frame_check;

`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST, par_en, par_type, bit_valid, bit_in, frame_abort, clr_err;
  logic [1:0] stop_num;
  logic       busy, frame_done, start_err, par_err, stop_err;
  logic [7:0] data_out;
  logic [2:0] sticky_err;
  logic [1:0] err_cnt_par, err_cnt_stop;

  int n_chk = 0;
  int n_err = 0;

  uart_rx_frame_check #(.DATA_WIDTH(8), .MAX_STOP_BITS(2), .CNT_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_type(par_type), .stop_num(stop_num),
    .bit_valid(bit_valid), .bit_in(bit_in), .frame_abort(frame_abort), .clr_err(clr_err),
    .busy(busy), .data_out(data_out), .frame_done(frame_done), .start_err(start_err),
    .par_err(par_err), .stop_err(stop_err), .sticky_err(sticky_err),
    .err_cnt_par(err_cnt_par), .err_cnt_stop(err_cnt_stop)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cyc();
    @(negedge CLK);
  endtask

  // Returns on the falling edge right after the capturing rising edge.
  task automatic send_bit(input logic b);
    @(negedge CLK);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge CLK);
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  // Start bit, 8 data bits LSB first, optional parity, then n_stop '1' stop bits.
  task automatic send_body(input logic [7:0] d, input bit has_par, input logic pbit, input int n_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    for (int i = 0; i < n_stop; i++) send_bit(1'b1);
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
  endtask

  initial begin
    RST = 1'b1; par_en = 1'b0; par_type = 1'b0; stop_num = 2'd1;
    bit_valid = 1'b0; bit_in = 1'b1; frame_abort = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    idle_cyc();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sticky", sticky_err, 0);
    chk("rst_flags", {start_err, par_err, stop_err}, 0);
    chk("rst_cnt", {err_cnt_par, err_cnt_stop}, 0);

    // 8N1 0xA5
    send_body(8'hA5, 0, 0, 0);
    chk("n1_busy_mid", busy, 1);
    chk("n1_no_early_done", frame_done, 0);
    send_bit(1'b1);
    chk("n1_done", frame_done, 1);
    chk("n1_data", data_out, 8'hA5);
    chk("n1_errs", {par_err, stop_err}, 2'b00);
    idle_cyc();
    chk("n1_done_pulse", frame_done, 0);
    chk("n1_busy_end", busy, 0);

    // 8E1 0x03 with wrong parity bit 1
    par_en = 1'b1; par_type = 1'b0;
    send_body(8'h03, 1, 1'b1, 0);
    send_bit(1'b1);
    chk("e1_done", frame_done, 1);
    chk("e1_par_err", par_err, 1);
    chk("e1_data", data_out, 8'h03);
    idle_cyc();
    chk("e1_sticky", sticky_err, 3'b010);
    chk("e1_cnt_par", err_cnt_par, CNT_ON ? 1 : 0);
    chk("e1_par_held", par_err, 1);

    // 8N2 0x55, second stop bit 0
    par_en = 1'b0; stop_num = 2'd2;
    send_body(8'h55, 0, 0, 1);
    chk("n2_no_early_done", frame_done, 0);
    chk("n2_busy", busy, 1);
    send_bit(1'b0);
    chk("n2_done", frame_done, 1);
    chk("n2_errs", {par_err, stop_err}, 2'b01);
    chk("n2_data", data_out, 8'h55);
    idle_cyc();
    chk("n2_sticky", sticky_err, 3'b110);
    chk("n2_cnt_stop", err_cnt_stop, CNT_ON ? 1 : 0);

    // Start error in IDLE, then clear racing a new start error
    send_bit(1'b1);
    chk("se_pulse", start_err, 1);
    chk("se_busy", busy, 0);
    idle_cyc();
    chk("se_pulse_end", start_err, 0);
    chk("se_sticky", sticky_err, 3'b111);
    pulse_clr();
    chk("clr_sticky", sticky_err, 3'b000);
    chk("clr_cnt", {err_cnt_par, err_cnt_stop}, 0);
    send_bit(1'b1);
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
    chk("clr_vs_set", sticky_err, 3'b001);

    // Abort after 4 data bits (abort coincides with a strobe), then a clean 0x3C
    stop_num = 2'd1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge CLK);
    frame_abort = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge CLK);
    frame_abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;
    chk("ab_busy", busy, 0);
    chk("ab_no_done", frame_done, 0);
    chk("ab_data_held", data_out, 8'h55);
    send_body(8'h3C, 0, 0, 0);
    send_bit(1'b1);
    chk("ab_next_done", frame_done, 1);
    chk("ab_next_data", data_out, 8'h3C);

    // Reset mid-frame, then a clean 0x96
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_data", data_out, 0);
    chk("rm_sticky", sticky_err, 0);
    send_body(8'h96, 0, 0, 0);
    send_bit(1'b1);
    chk("rm_next_done", frame_done, 1);
    chk("rm_next_data", data_out, 8'h96);

    // 8O1 0x07 (three ones) with parity bit 0 is correct
    par_en = 1'b1; par_type = 1'b1;
    send_body(8'h07, 1, 1'b0, 0);
    send_bit(1'b1);
    chk("o1_done", frame_done, 1);
    chk("o1_par_ok", par_err, 0);
    chk("o1_data", data_out, 8'h07);

    // 8O1 0x07 with parity bit 1 is an error
    send_body(8'h07, 1, 1'b1, 0);
    send_bit(1'b1);
    chk("o1b_par_err", par_err, 1);

    // stop_num=0 acts as one stop bit
    par_en = 1'b0; stop_num = 2'd0;
    send_body(8'h81, 0, 0, 0);
    send_bit(1'b1);
    chk("s0_done", frame_done, 1);
    chk("s0_data", data_out, 8'h81);
    chk("s0_par_forced", par_err, 0);

    // stop_num=3 clamps to two stop bits
    stop_num = 2'd3;
    send_body(8'h42, 0, 0, 1);
    chk("s3_no_early_done", frame_done, 0);
    send_bit(1'b1);
    chk("s3_done", frame_done, 1);
    chk("s3_data_errs", {data_out, par_err, stop_err}, {8'h42, 2'b00});

    // Config change after the start bit is ignored for this frame
    stop_num = 2'd1; par_en = 1'b0;
    send_bit(1'b0);
    par_en = 1'b1; stop_num = 2'd2; par_type = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(i < 4);
    send_bit(1'b1);
    chk("cfg_done", frame_done, 1);
    chk("cfg_data", data_out, 8'h0F);

    // Parity counter saturates at 3 with 2-bit width
    par_en = 1'b1; par_type = 1'b0; stop_num = 2'd1;
    pulse_clr();
    for (int k = 1; k <= 4; k++) begin
      send_body(8'h03, 1, 1'b1, 0);
      send_bit(1'b1);
      idle_cyc();
      chk($sformatf("sat_cnt_%0d", k), err_cnt_par, CNT_ON ? ((k > 3) ? 3 : k) : 0);
    end
    chk("sat_sticky", sticky_err, 3'b010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
- Parametrised successor to the single-bit UART RX stop checker.
- Consumes sampled bits from data sampling, one strobe per bit, and tracks the whole frame: start, data LSB-first, optional parity, 1..MAX_STOP_BITS stop bits.
- Emits the assembled data word with per-frame start/parity/stop error flags and sticky error status.
- Sits between data_sampling and the RX FSM/deserializer output stage.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- MAX_STOP_BITS, 2, largest supported stop bit count; legal 1..4.
- CNT_WIDTH, 8, width of each error counter (used only with ERR_CNT_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- par_en  in  1  parity bit present.
- par_type  in  1  0 = even, 1 = odd.
- stop_num  in  $clog2(MAX_STOP_BITS+1)  stop bits expected; 0 acts as 1; values above MAX_STOP_BITS act as MAX_STOP_BITS.
- bit_valid  in  1  one-cycle strobe; bit_in holds a sampled bit.
- bit_in  in  1  sampled bit value.
- frame_abort  in  1  drop the current frame and return to IDLE.
- clr_err  in  1  clears sticky status and counters.
- busy  out  1  high in any state other than IDLE.
- data_out  out  DATA_WIDTH  assembled word; held until the next frame_done.
- frame_done  out  1  one-cycle pulse; frame complete.
- start_err  out  1  one-cycle pulse; bit_valid with bit_in=1 seen in IDLE.
- par_err  out  1  parity result of the last frame; valid with frame_done, held until it.
- stop_err  out  1  any stop bit of the last frame was 0; valid with frame_done, held until it.
- sticky_err  out  3  {stop, par, start} sticky status bits.
- err_cnt_par  out  CNT_WIDTH  saturating parity-error count (ERR_CNT_EN only).
- err_cnt_stop  out  CNT_WIDTH  saturating stop-error count (ERR_CNT_EN only).

Behaviour:
- Reset (RST=1 at a CLK edge): all outputs 0, state IDLE, counters 0. Reset mid-frame discards the frame with no frame_done.
- Only cycles with bit_valid=1 advance the FSM; all other cycles hold state.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - bit_valid with bit_in=0: latch par_en, par_type and the clamped stop_num into frame config; clear the parity accumulator; go to DATA.
  - bit_valid with bit_in=1: pulse start_err on the next cycle; stay in IDLE.
- DATA:
  - Shift bit_in into the shift register, LSB first; XOR it into the parity accumulator.
  - After DATA_WIDTH bits, go to PARITY if latched par_en, else STOP.
- PARITY:
  - par_err_next = accumulator ^ bit_in ^ latched par_type. Nonzero means error; even parity expects total ones even.
  - Go to STOP.
- STOP:
  - Accumulate stop_err_next |= ~bit_in.
  - On the last expected stop bit, the next cycle pulses frame_done, updates data_out/par_err/stop_err, and returns to IDLE.
  - When par_en=0, par_err is forced to 0.
- Latency: frame_done is registered, one cycle after the CLK edge that captured the last stop bit.
- Stop bits after the first are still checked; no early done on error.
- frame_abort has priority over bit_valid in the same cycle: go to IDLE, no frame_done, outputs held. In IDLE it is a no-op.
- Config inputs changing mid-frame have no effect until the next start bit.
- sticky_err bits set on start_err pulses and on frame_done with par_err/stop_err. clr_err clears them; if set and clear occur in the same cycle, set wins.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- Defined: err_cnt_par and err_cnt_stop increment on frame_done with the matching error. They saturate at all ones and clear on clr_err (increment wins if simultaneous, result 1).
- Undefined: counters not built; both ports tied to 0.

Decomposition:
- Shared package uart_rx_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
  - sticky_err bit index constants STICKY_START=0, STICKY_PAR=1, STICKY_STOP=2.
- Sub-module sat_counter, parametrised by CNT_WIDTH, with inc/clr/saturate; instantiated twice under the macro.

Test Plan:
- 8N1 frame, 0xA5 (bits 0,1,0,1,0,0,1,0,1,1 incl. start/stop) -> frame_done one cycle after stop strobe; data_out=0xA5, par_err=0, stop_err=0.
- 8E1 with 0x03 and parity bit 1 -> par_err=1, sticky_err=3'b010; err_cnt_par=1 with macro.
- stop_num=2, 8N2 frame 0x55 with second stop bit 0 -> stop_err=1 at frame_done, sticky_err[2]=1.
- IDLE, bit_valid with bit_in=1 -> start_err pulse one cycle, busy stays 0; then clr_err in the same cycle as a new start_err -> sticky_err[0] remains 1.
- frame_abort after 4 data bits, then a clean 0x3C frame -> no frame_done for the aborted frame; next data_out=0x3C. RST mid-frame behaves the same.
- Macro on, CNT_WIDTH=2, four parity-error frames -> err_cnt_par reads 1, 2, 3, 3 (saturated).
